seq_detector_param: RTL and testbench

- Parametrised successor to the fixed 3-bit-state serial Moore machine.
- Detects a configurable N-bit serial pattern on input x, with selectable overlap or non-overlap mode and a qualifying VALID strobe.
- Exposes the match-progress state S, a Moore match flag F and a saturating hit counter.
- Sits between the serial bit source and downstream control logic that consumes F or HIT_CNT.

---
 rtl/seq_det_pkg.sv | 50 +++++
 rtl/seq_det_next_state.sv | 34 +++
 rtl/seq_detector_param.sv | 61 ++++++
 tb/tb_seq_detector_param.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared helpers for the parametrised serial pattern detector: width helper,
// overlap-mode constants and the elaboration-time KMP transition function.
package seq_det_pkg;

    localparam int MODE_OVERLAP     = 1;
    localparam int MODE_NON_OVERLAP = 0;

    // Ceiling log2, minimum 0; used to size the progress state.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Next progress state from state k on bit xb. Covers both the match and
    // mismatch cases: the longest pattern prefix that is a suffix of
    // (k matched bits followed by xb). From a full match in non-overlap mode
    // the history is dropped and the search restarts from empty.
    function automatic int fail_next(input int k, input logic xb,
                                     input logic [7:0] pat, input int n,
                                     input int overlap);
        logic [8:0] seq;
        int         kk;
        int         len;
        int         best;
        bit         ok;
        kk = (k >= n && overlap == MODE_NON_OVERLAP) ? 0 : k;
        seq = '0;
        for (int i = 0; i < 8; i++)
            if (i < kk)
                seq = seq | (((9'(pat) >> (n - 1 - i)) & 9'd1) << i);
        seq  = seq | (9'(xb) << kk);
        len  = kk + 1;
        best = 0;
        for (int j = 1; j <= 8; j++) begin
            if (j <= n && j <= len) begin
                ok = 1'b1;
                for (int t = 0; t < 8; t++)
                    if (t < j &&
                        (((seq >> (len - j + t)) & 9'd1) !=
                         ((9'(pat) >> (n - 1 - t)) & 9'd1)))
                        ok = 1'b0;
                if (ok) best = j;
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/seq_det_next_state.sv
// Combinational next-state table for the detector. Every (state, bit) entry
// is a constant resolved at elaboration; the runtime logic is a mux.
module seq_det_next_state
    import seq_det_pkg::*;
#(
    parameter int           N       = 4,
    parameter logic [N-1:0] PATTERN = 4'b1011,
    parameter int           OVERLAP = MODE_OVERLAP,
    localparam int          SW      = clog2(N + 1)
) (
    input  logic [SW-1:0] s,
    input  logic          x,
    output logic [SW-1:0] nxt
);

    localparam logic [7:0] PAT8 = 8'(PATTERN);

    // OR-chain of per-state selections; states above N are unreachable and
    // fall through to 0.
    logic [SW-1:0] acc [0:N+1];
    assign acc[0] = '0;

    genvar k;
    generate
        for (k = 0; k <= N; k++) begin : g_state
            localparam logic [SW-1:0] NXT0 = SW'(fail_next(k, 1'b0, PAT8, N, OVERLAP));
            localparam logic [SW-1:0] NXT1 = SW'(fail_next(k, 1'b1, PAT8, N, OVERLAP));
            assign acc[k+1] = acc[k] | ((s == SW'(k)) ? (x ? NXT1 : NXT0) : '0);
        end
    endgenerate

    assign nxt = acc[N+1];

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector: progress state register, Moore match
// flag and a saturating hit counter. Define SEQDET_MEALY_EN to add the
// combinational F_EARLY output that flags a match one cycle before F.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int           N       = 4,
    parameter logic [N-1:0] PATTERN = 4'b1011,
    parameter int           OVERLAP = MODE_OVERLAP,
    parameter int           CNT_W   = 8,
    localparam int          SW      = clog2(N + 1)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             VALID,
    input  logic             x,
`ifdef SEQDET_MEALY_EN
    output logic             F_EARLY,
`endif
    output logic             F,
    output logic [SW-1:0]    S,
    output logic [CNT_W-1:0] HIT_CNT
);

    localparam logic [SW-1:0] S_FULL = SW'(N);

    logic [SW-1:0]    st;
    logic [SW-1:0]    nxt;
    logic [CNT_W-1:0] cnt;

    seq_det_next_state #(
        .N       (N),
        .PATTERN (PATTERN),
        .OVERLAP (OVERLAP)
    ) u_next (
        .s   (st),
        .x   (x),
        .nxt (nxt)
    );

    // State advance and hit counting on accepted bits; reset wins over VALID.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            st  <= '0;
            cnt <= '0;
        end else if (VALID) begin
            st <= nxt;
            if (nxt == S_FULL && cnt != '1)
                cnt <= cnt + CNT_W'(1);
        end
    end

    assign S       = st;
    assign F       = (st == S_FULL);
    assign HIT_CNT = cnt;

`ifdef SEQDET_MEALY_EN
    assign F_EARLY = VALID & RESET & (nxt == S_FULL);
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: three instances share the stimulus
// (overlap, non-overlap, and a 2-bit counter overlap build).
module tb_seq_detector_param;

    logic CLK = 1'b0;
    logic RESET;
    logic VALID;
    logic x;

    logic [2:0] s_ov, s_no, s_sat;
    logic       f_ov, f_no, f_sat;
    logic [7:0] h_ov, h_no;
    logic [1:0] h_sat;
`ifdef SEQDET_MEALY_EN
    logic       fe_ov, fe_no, fe_sat;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    seq_detector_param #(.N(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(8)) d_ov (
        .CLK(CLK), .RESET(RESET), .VALID(VALID), .x(x),
`ifdef SEQDET_MEALY_EN
        .F_EARLY(fe_ov),
`endif
        .F(f_ov), .S(s_ov), .HIT_CNT(h_ov));

    seq_detector_param #(.N(4), .PATTERN(4'b1011), .OVERLAP(0), .CNT_W(8)) d_no (
        .CLK(CLK), .RESET(RESET), .VALID(VALID), .x(x),
`ifdef SEQDET_MEALY_EN
        .F_EARLY(fe_no),
`endif
        .F(f_no), .S(s_no), .HIT_CNT(h_no));

    seq_detector_param #(.N(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(2)) d_sat (
        .CLK(CLK), .RESET(RESET), .VALID(VALID), .x(x),
`ifdef SEQDET_MEALY_EN
        .F_EARLY(fe_sat),
`endif
        .F(f_sat), .S(s_sat), .HIT_CNT(h_sat));

    // Drive one bit, let one edge pass, sample 1 time unit after it.
    task automatic step(input logic v, input logic b);
        VALID = v;
        x     = b;
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset();
        RESET = 1'b0;
        step(1'b0, 1'b0);
        RESET = 1'b1;
    endtask

    task automatic test_reset();
        RESET = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step(1'b1, (i == 0));
            n_checks++;
            if ({s_ov, f_ov, h_ov} !== 12'h0) begin
                n_fail++;
                $display("FAIL reset_ov cyc%0d: got S=%0d F=%0b HIT=%0d want 0/0/0", i, s_ov, f_ov, h_ov);
            end
            n_checks++;
            if ({s_no, f_no, h_no} !== 12'h0) begin
                n_fail++;
                $display("FAIL reset_no cyc%0d: got S=%0d F=%0b HIT=%0d want 0/0/0", i, s_no, f_no, h_no);
            end
            n_checks++;
            if ({s_sat, f_sat, h_sat} !== 6'h0) begin
                n_fail++;
                $display("FAIL reset_sat cyc%0d: got S=%0d F=%0b HIT=%0d want 0/0/0", i, s_sat, f_sat, h_sat);
            end
        end
        RESET = 1'b1;
    endtask

    // Stream 1,0,1,1,0,1,1 directly after reset release.
    task automatic test_overlap();
        logic [6:0] bits;
        int ov_s [7];
        int no_s [7];
        int ov_h [7];
        int no_h [7];
        bits = 7'b1011011;
        ov_s = '{1, 2, 3, 4, 2, 3, 4};
        no_s = '{1, 2, 3, 4, 0, 1, 1};
        ov_h = '{0, 0, 0, 1, 1, 1, 2};
        no_h = '{0, 0, 0, 1, 1, 1, 1};
        for (int i = 0; i < 7; i++) begin
            step(1'b1, bits[6-i]);
            n_checks++;
            if ({s_ov, f_ov, h_ov} !== {3'(ov_s[i]), (ov_s[i] == 4), 8'(ov_h[i])}) begin
                n_fail++;
                $display("FAIL overlap bit%0d: got S=%0d F=%0b HIT=%0d want S=%0d F=%0b HIT=%0d",
                         i + 1, s_ov, f_ov, h_ov, ov_s[i], (ov_s[i] == 4), ov_h[i]);
            end
            n_checks++;
            if ({s_no, f_no, h_no} !== {3'(no_s[i]), (no_s[i] == 4), 8'(no_h[i])}) begin
                n_fail++;
                $display("FAIL non_overlap bit%0d: got S=%0d F=%0b HIT=%0d want S=%0d F=%0b HIT=%0d",
                         i + 1, s_no, f_no, h_no, no_s[i], (no_s[i] == 4), no_h[i]);
            end
        end
    endtask

    // 1,0,1,1 with three VALID=0 cycles after each bit; x is noisy in gaps.
    task automatic test_valid_gaps();
        logic [3:0] bits;
        bits = 4'b1011;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, bits[3-i]);
            for (int g = 0; g < 4; g++) begin
                n_checks++;
                if ({s_ov, f_ov, h_ov} !== {3'(i + 1), (i == 3), 8'(i == 3)}) begin
                    n_fail++;
                    $display("FAIL valid_gap bit%0d gap%0d: got S=%0d F=%0b HIT=%0d want S=%0d F=%0b HIT=%0d",
                             i + 1, g, s_ov, f_ov, h_ov, i + 1, (i == 3), (i == 3));
                end
                if (g < 3) begin
                    VALID = 1'b0;
                    x     = (g == 1);
                    #1;
`ifdef SEQDET_MEALY_EN
                    n_checks++;
                    if (fe_ov !== 1'b0) begin
                        n_fail++;
                        $display("FAIL valid_gap_early bit%0d gap%0d: got %0b want 0", i + 1, g, fe_ov);
                    end
`endif
                    @(posedge CLK);
                    #1;
                end
            end
        end
        n_checks++;
        if (h_no !== 8'd1) begin
            n_fail++;
            $display("FAIL valid_gap_no_hit: got %0d want 1", h_no);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        n_checks++;
        if (s_ov !== 3'd3) begin
            n_fail++;
            $display("FAIL reset_mid_pre: got S=%0d want 3", s_ov);
        end
        RESET = 1'b0;
`ifdef SEQDET_MEALY_EN
        VALID = 1'b1;
        x     = 1'b1;
        #1;
        n_checks++;
        if (fe_ov !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_early: got %0b want 0", fe_ov);
        end
`endif
        step(1'b1, 1'b1);
        RESET = 1'b1;
        n_checks++;
        if ({s_ov, f_ov, h_ov} !== 12'h0) begin
            n_fail++;
            $display("FAIL reset_mid_clear: got S=%0d F=%0b HIT=%0d want 0/0/0", s_ov, f_ov, h_ov);
        end
        step(1'b1, 1'b1);
        n_checks++;
        if ({s_ov, f_ov, h_ov} !== {3'd1, 1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL reset_mid_after: got S=%0d F=%0b HIT=%0d want 1/0/0", s_ov, f_ov, h_ov);
        end
    endtask

    // 1011 repeated five times: 2-bit counter pins at 3, 8-bit counts to 5.
    task automatic test_saturation();
        logic [3:0] bits;
        int         eh;
        bits = 4'b1011;
        apply_reset();
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 4; i++) begin
                VALID = 1'b1;
                x     = bits[3-i];
                #1;
`ifdef SEQDET_MEALY_EN
                n_checks++;
                if (fe_sat !== (i == 3)) begin
                    n_fail++;
                    $display("FAIL sat_early rep%0d bit%0d: got %0b want %0b", r, i + 1, fe_sat, (i == 3));
                end
`endif
                @(posedge CLK);
                #1;
                eh = r + ((i == 3) ? 1 : 0);
                n_checks++;
                if ({s_sat, f_sat, h_sat} !== {3'(i + 1), (i == 3), 2'((eh > 3) ? 3 : eh)}) begin
                    n_fail++;
                    $display("FAIL saturation rep%0d bit%0d: got S=%0d F=%0b HIT=%0d want S=%0d F=%0b HIT=%0d",
                             r, i + 1, s_sat, f_sat, h_sat, i + 1, (i == 3), (eh > 3) ? 3 : eh);
                end
            end
        end
        n_checks++;
        if (h_ov !== 8'd5) begin
            n_fail++;
            $display("FAIL sat_wide_count: got %0d want 5", h_ov);
        end
        n_checks++;
        if (h_no !== 8'd5) begin
            n_fail++;
            $display("FAIL sat_no_count: got %0d want 5", h_no);
        end
    endtask

    initial begin
        RESET = 1'b0;
        VALID = 1'b0;
        x     = 1'b0;
        test_reset();
        test_overlap();
        test_valid_gaps();
        test_reset_mid();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
